seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
- Transaction sequencer between one requester and one downstream processing unit.
- Converts a req/ack request into a start/rdy/endd sequence on the unit.
- Aborts the unit with stop on er or watchdog expiry, reports each outcome through status_valid/status_err, and raises a sticky interrupt on failure.
- Instantiated beside the unit it controls; all handshake signals are single-bit, level-sampled on clk.

Parameters:
- TIMEOUT, 16, watchdog limit in cycles spent in WAIT_RDY+BUSY (>=2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  gates acceptance of new requests only.
- req  in  1  requester asks for one transaction.
- ack  out  1  one-cycle pulse: transaction finished (pass or fail).
- start  out  1  one-cycle pulse to the unit.
- rdy  in  1  unit accepted start.
- endd  in  1  unit finished.
- er  in  1  unit error.
- stop  out  1  one-cycle abort pulse to the unit.
- status_valid  out  1  one-cycle pulse, coincident with ack.
- status_err  out  1  valid with status_valid: 1 = aborted.
- interrupt  out  1  sticky error flag.
- int_clr  in  1  clears interrupt.
- busy  out  1  high in any state except IDLE.
- err_cnt  out  CNT_W  saturating count of aborted transactions.

Behaviour:
- Reset: state=IDLE, all outputs 0, err_cnt=0, watchdog=0. Reset mid-transaction abandons it silently: no stop, no ack.
- Outputs are registered, Moore-decoded from state.
- IDLE: enable && req -> START. Otherwise stay. req is sampled only in IDLE.
- START: start=1 for exactly one cycle -> WAIT_RDY. Watchdog cleared.
- WAIT_RDY, priority order:
  - er -> ABORT
  - rdy -> BUSY
  - watchdog expired -> ABORT
  - else stay, watchdog++.
- BUSY, priority order:
  - er -> ABORT (er beats endd in the same cycle)
  - endd -> DONE
  - watchdog expired -> ABORT
  - else stay, watchdog++. The watchdog is not cleared on rdy.
- DONE: ack=1, status_valid=1, status_err=0 for one cycle -> IDLE.
- ABORT: stop=1, ack=1, status_valid=1, status_err=1 for one cycle; interrupt set; err_cnt+1 saturating at 2^CNT_W-1 -> IDLE.
- Latency:
  - req to start: 1 cycle.
  - endd to ack: 1 cycle.
  - Minimum transaction (req cycle 0): start cycle 1, rdy cycle 2, endd cycle 3, ack cycle 4.
  - req held high: the next start follows 2 cycles after ack (one IDLE cycle between).
- Watchdog: expires when the count equals TIMEOUT-1, so ABORT occurs after exactly TIMEOUT cycles in WAIT_RDY+BUSY. An event arriving in the expiry cycle takes priority.
- rdy/endd/er outside WAIT_RDY/BUSY are ignored. A second rdy in BUSY is ignored.
- enable deasserted mid-transaction: the transaction completes normally.
- interrupt: set in ABORT, cleared by int_clr. Set wins over a same-cycle clear.
- Invariants: start, stop and ack are never high together except stop+ack in ABORT. start only when busy was 0 the previous cycle.

Optional Feature:
- Macro: SEQ_CTRL_WATCHDOG_EN.
- Defined: watchdog counter and timeout-abort paths as above.
- Undefined: no counter is synthesised; WAIT_RDY/BUSY wait indefinitely for rdy/endd/er. TIMEOUT is unused.

Decomposition:
- Shared package seq_ctrl_pkg holds:
  - state enum seq_state_e {IDLE, START, WAIT_RDY, BUSY, DONE, ABORT}, 3-bit encoded.
  - status typedef struct {logic err;}.
  - localparam function for watchdog width = $clog2(TIMEOUT).
- One natural sub-module: seq_wdog (clear/enable/expired counter), instantiated only under SEQ_CTRL_WATCHDOG_EN.
- SVA handshake properties live in the bind/test top, not in the RTL.

Test Plan:
- Nominal: enable=1, req at cycle 0, rdy at 2, endd at 3 -> start=1 at cycle 1; ack=status_valid=1, status_err=0 at cycle 4; err_cnt=0; interrupt=0.
- Error in BUSY: rdy at 2, er and endd both at 5 -> stop=ack=status_err=1 at cycle 6; interrupt=1; err_cnt=1. Then int_clr at 8 -> interrupt=0 at cycle 9.
- Watchdog (macro defined, TIMEOUT=16): start at 1, never rdy -> ABORT at cycle 18 with stop=1, status_err=1. Macro undefined: busy stays 1 for 1000 cycles with no ack.
- Gating: enable=0 with req=1 for 10 cycles -> start never asserts. Deassert enable during BUSY -> the transaction still acks.
- Back-to-back: req held high across two transactions -> the second start occurs 2 cycles after the first ack. Spurious rdy/endd in IDLE cause no output change.
- Reset: assert rst during BUSY -> all outputs 0 immediately (asynchronous), no ack/stop. After release, err_cnt=0 and a new req is accepted.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types for the transaction sequencer.
// Holds the FSM state encoding, the status bundle and the watchdog width helper.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_RDY = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4,
        ABORT    = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic err;
    } seq_status_t;

    // Counter width able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/seq_ctrl_wdog.sv
// seq_wdog: watchdog counter for the sequencer.
// Ports: clk, rst (async, high), clr (zero the count), en (count up), expired (count == TIMEOUT-1).
module seq_wdog
    import seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = wdog_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == LIMIT);

    // Holds at the limit so a late event in the expiry cycle still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: sequences one req/ack transaction into start/rdy/endd on a unit,
// aborting with stop on er or (with SEQ_CTRL_WATCHDOG_EN) a watchdog timeout.
// Ports: clk, rst (async, high); enable, req, ack (requester side);
//        start, rdy, endd, er, stop (unit side); status_valid, status_err,
//        interrupt, int_clr, busy, err_cnt (status side).
// Macro SEQ_CTRL_WATCHDOG_EN: adds the watchdog counter and timeout-abort paths.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req,
    output logic             ack,
    output logic             start,
    input  logic             rdy,
    input  logic             endd,
    input  logic             er,
    output logic             stop,
    output logic             status_valid,
    output logic             status_err,
    output logic             interrupt,
    input  logic             int_clr,
    output logic             busy,
    output logic [CNT_W-1:0] err_cnt
);

    seq_state_e  state;
    seq_state_e  state_nx;
    seq_status_t status_q;
    logic        wd_expired;

`ifdef SEQ_CTRL_WATCHDOG_EN
    logic wd_clr;
    logic wd_en;

    // Count only while waiting in place; a transition leaves the count alone.
    assign wd_clr = (state == START);
    assign wd_en  = ((state == WAIT_RDY) || (state == BUSY))
                 && (state_nx == state);

    seq_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable && req) begin
                    state_nx = START;
                end
            end
            START: begin
                state_nx = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (er) begin
                    state_nx = ABORT;
                end else if (rdy) begin
                    state_nx = BUSY;
                end else if (wd_expired) begin
                    state_nx = ABORT;
                end
            end
            BUSY: begin
                if (er) begin
                    state_nx = ABORT;
                end else if (endd) begin
                    state_nx = DONE;
                end else if (wd_expired) begin
                    state_nx = ABORT;
                end
            end
            DONE:    state_nx = IDLE;
            ABORT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state into flops so they line up
    // with the state they belong to without any combinational path out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start        <= 1'b0;
            stop         <= 1'b0;
            ack          <= 1'b0;
            status_valid <= 1'b0;
            status_q     <= '0;
            busy         <= 1'b0;
        end else begin
            start        <= (state_nx == START);
            stop         <= (state_nx == ABORT);
            ack          <= (state_nx == DONE) || (state_nx == ABORT);
            status_valid <= (state_nx == DONE) || (state_nx == ABORT);
            status_q.err <= (state_nx == ABORT);
            busy         <= (state_nx != IDLE);
        end
    end

    assign status_err = status_q.err;

    // Setting on abort takes precedence over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interrupt <= 1'b0;
        end else if (state_nx == ABORT) begin
            interrupt <= 1'b1;
        end else if (int_clr) begin
            interrupt <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((state_nx == ABORT) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scoreboard bench for seq_ctrl.
// Stimulus pushes expected completions; a negedge monitor pops and checks them.
module tb_seq_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             req;
    logic             ack;
    logic             start;
    logic             rdy;
    logic             endd;
    logic             er;
    logic             stop;
    logic             status_valid;
    logic             status_err;
    logic             interrupt;
    logic             int_clr;
    logic             busy;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .ack         (ack),
        .start       (start),
        .rdy         (rdy),
        .endd        (endd),
        .er          (er),
        .stop        (stop),
        .status_valid(status_valid),
        .status_err  (status_err),
        .interrupt   (interrupt),
        .int_clr     (int_clr),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(start && (stop || ack)))
        else $error("start overlapped stop/ack");
    a_stop: assert property (@(posedge clk) disable iff (rst)
        stop |-> ack)
        else $error("stop without ack");
    a_start: assert property (@(posedge clk) disable iff (rst)
        start |-> $past(!busy))
        else $error("start while busy");

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ack(input int c, input logic e);
        exp_t x;
        if (e) exp_cnt = exp_cnt + 8'd1;
        x.cyc = c;
        x.err = e;
        x.cnt = exp_cnt;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst && (ack || status_valid || stop)) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {ack, status_valid, stop}, 3'b000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_flags", {start, ack, status_valid, stop, status_err},
                    {1'b0, 1'b1, 1'b1, e.err, e.err});
                chk("ack_err_cnt", err_cnt, e.cnt);
                if (e.err) chk("ack_interrupt", interrupt, 1'b1);
            end
        end
    end

    task automatic run_nominal();
        int t0;
        t0 = cyc;
        expect_ack(t0 + 4, 1'b0);
        enable = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("nom_start", {start, busy}, 2'b11);
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        endd = 1'b1;
        tick();
        endd = 1'b0;
        tick(2);
    endtask

    initial begin
        logic bad;
        int   t0;
        rst = 1'b1;
        enable = 1'b0;
        req = 1'b0;
        rdy = 1'b0;
        endd = 1'b0;
        er = 1'b0;
        int_clr = 1'b0;
        tick(3);
        chk("reset_outputs",
            {start, stop, ack, status_valid, status_err, interrupt, busy, err_cnt},
            '0);
        rst = 1'b0;
        tick();

        // Nominal transaction.
        run_nominal();
        chk("nom_interrupt", interrupt, 1'b0);

        // er and endd together in BUSY: error wins.
        t0 = cyc;
        expect_ack(t0 + 6, 1'b1);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick(2);
        er = 1'b1;
        endd = 1'b1;
        tick();
        er = 1'b0;
        endd = 1'b0;
        chk("busy_err_int", interrupt, 1'b1);
        tick(2);
        int_clr = 1'b1;
        chk("int_before_clr", interrupt, 1'b1);
        tick();
        int_clr = 1'b0;
        chk("int_cleared", interrupt, 1'b0);

        // er in WAIT_RDY with a simultaneous clear: set wins.
        t0 = cyc;
        expect_ack(t0 + 3, 1'b1);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        er = 1'b1;
        int_clr = 1'b1;
        tick();
        er = 1'b0;
        chk("int_set_wins", interrupt, 1'b1);
        tick();
        int_clr = 1'b0;
        chk("int_clr_after", interrupt, 1'b0);
        tick();

`ifdef SEQ_CTRL_WATCHDOG_EN
        // No rdy: abort after TIMEOUT cycles waiting.
        t0 = cyc;
        expect_ack(t0 + 2 + TIMEOUT, 1'b1);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(TIMEOUT);
        chk("wd_pre_expiry", {busy, ack}, 2'b10);
        tick(3);
        // rdy and endd arriving in expiry cycles take priority.
        t0 = cyc;
        expect_ack(t0 + 3 + TIMEOUT, 1'b0);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(TIMEOUT);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        endd = 1'b1;
        tick();
        endd = 1'b0;
        tick(3);
`else
        // No watchdog: waits indefinitely for rdy.
        req = 1'b1;
        tick();
        req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!busy || ack || stop) bad = 1'b1;
        end
        chk("nowd_hang", bad, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        tick();
`endif

        // Gating: enable low blocks requests.
        enable = 1'b0;
        req = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start || busy) bad = 1'b1;
        end
        chk("gate_blocks", bad, 1'b0);
        req = 1'b0;
        tick();

        // enable dropped mid-transaction: still completes.
        t0 = cyc;
        expect_ack(t0 + 5, 1'b0);
        enable = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        enable = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        endd = 1'b1;
        tick();
        endd = 1'b0;
        tick(2);
        enable = 1'b1;

        // Back-to-back with req held.
        t0 = cyc;
        expect_ack(t0 + 4, 1'b0);
        expect_ack(t0 + 9, 1'b0);
        req = 1'b1;
        tick();
        chk("b2b_start1", start, 1'b1);
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        endd = 1'b1;
        tick();
        endd = 1'b0;
        tick();
        chk("b2b_gap", {start, busy}, 2'b00);
        tick();
        chk("b2b_start2", start, 1'b1);
        req = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        endd = 1'b1;
        tick();
        endd = 1'b0;
        tick(2);

        // Spurious unit handshakes in IDLE.
        rdy = 1'b1;
        endd = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (start || stop || ack || busy || status_valid) bad = 1'b1;
        end
        rdy = 1'b0;
        endd = 1'b0;
        chk("spurious_idle", bad, 1'b0);
        tick();

        // Reset during BUSY after an earlier abort.
        if (exp_cnt == 8'd0) begin
            expect_ack(cyc + 3, 1'b1);
            req = 1'b1;
            tick();
            req = 1'b0;
            tick();
            er = 1'b1;
            tick();
            er = 1'b0;
            tick(2);
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_reset",
            {start, stop, ack, status_valid, status_err, interrupt, busy, err_cnt},
            '0);
        tick(2);
        rst = 1'b0;
        exp_cnt = 8'd0;
        tick();
        chk("post_reset_cnt", err_cnt, 8'd0);
        run_nominal();

        tick(3);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
